// File: rtl/wb_timer_ctrl_mc.sv
// Wishbone-slave multi-channel down-counter timer with a shared prescaler,
// one-shot/periodic channels, per-channel expiry pulses and a sticky maskable interrupt.
module wb_timer_ctrl_mc #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned PRE_WIDTH = 16,
    parameter logic [15:0] DEV_ID    = 16'hC008
) (
    input  logic              WB_CLK,
    input  logic              WB_RST,
    input  logic [16:0]       WBs_ADR,
    input  logic              WBs_CYC,
    input  logic [3:0]        WBs_BYTE_STB,
    input  logic              WBs_WE,
    input  logic              WBs_RD,
    input  logic              WBs_STB,
    input  logic [31:0]       WBs_WR_DAT,
    output logic [31:0]       WBs_RD_DAT,
    output logic              WBs_ACK,
    output logic [NUM_CH-1:0] tmr_pulse_o,
    output logic              FPGA_INTR
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [5:0] A_ID   = 6'h00;
    localparam logic [5:0] A_STAT = 6'h01;
    localparam logic [5:0] A_EN   = 6'h02;
    localparam logic [5:0] A_PRE  = 6'h03;

    logic                 req;
    logic                 wr;
    logic                 rd;
    logic [5:0]           idx;
    logic                 tick;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [PRE_WIDTH-1:0] prescale;
    logic [PRE_WIDTH-1:0] prescale_d;
    logic [NUM_CH-1:0]    int_stat;
    logic [NUM_CH-1:0]    int_stat_d;
    logic [NUM_CH-1:0]    int_en;
    logic [NUM_CH-1:0]    int_en_d;
    logic [NUM_CH-1:0]    expire;
    logic [NUM_CH-1:0]    mode;
    logic [NUM_CH-1:0]    mode_d;
    logic [NUM_CH-1:0]    ctrl_wr;
    logic [NUM_CH-1:0]    load_wr;
    state_t               state   [NUM_CH];
    state_t               state_d [NUM_CH];
    logic [CNT_WIDTH-1:0] load    [NUM_CH];
    logic [CNT_WIDTH-1:0] load_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] count   [NUM_CH];
    logic [CNT_WIDTH-1:0] count_d [NUM_CH];
    logic [31:0]          rd_d;
    logic                 unused_ok;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return r;
    endfunction

    assign req       = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign wr        = req & WBs_WE;
    assign rd        = req & ~WBs_WE;
    assign idx       = WBs_ADR[7:2];
    assign tick      = (pre_cnt == prescale);
    assign FPGA_INTR = |(int_stat & int_en);
    assign unused_ok = ^{WBs_RD, WBs_ADR[16:8], WBs_ADR[1:0]};

    always_comb begin
        prescale_d = prescale;
        int_en_d   = int_en;
        int_stat_d = int_stat;
        if (wr && idx == A_PRE)
            prescale_d = PRE_WIDTH'(merge_bytes(32'(prescale), WBs_WR_DAT, WBs_BYTE_STB));
        if (wr && idx == A_EN)
            int_en_d = NUM_CH'(merge_bytes(32'(int_en), WBs_WR_DAT, WBs_BYTE_STB));
        if (wr && idx == A_STAT && WBs_BYTE_STB[0])
            int_stat_d = int_stat & ~WBs_WR_DAT[NUM_CH-1:0];
        // hardware set is applied after the clear so a same-cycle expiry wins
        int_stat_d = int_stat_d | expire;
    end

    always_comb begin
        rd_d = '0;
        case (idx)
            A_ID:    rd_d = {DEV_ID, 8'(NUM_CH), 8'(CNT_WIDTH)};
            A_STAT:  rd_d = 32'(int_stat);
            A_EN:    rd_d = 32'(int_en);
            A_PRE:   rd_d = 32'(prescale);
            default: ;
        endcase
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (idx == 6'(4 * (n + 1)))     rd_d = {30'd0, mode[n], state[n] == S_RUN};
            if (idx == 6'(4 * (n + 1) + 1)) rd_d = 32'(load[n]);
            if (idx == 6'(4 * (n + 1) + 2)) rd_d = 32'(count[n]);
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            ctrl_wr[n] = wr && (idx == 6'(4 * (n + 1))) && WBs_BYTE_STB[0];
            load_wr[n] = wr && (idx == 6'(4 * (n + 1) + 1));
            state_d[n] = state[n];
            mode_d[n]  = mode[n];
            load_d[n]  = load[n];
            count_d[n] = count[n];
            expire[n]  = 1'b0;
            if (ctrl_wr[n]) mode_d[n] = WBs_WR_DAT[1];
            if (load_wr[n])
                load_d[n] = CNT_WIDTH'(merge_bytes(32'(load[n]), WBs_WR_DAT, WBs_BYTE_STB));
            case (state[n])
                S_IDLE: begin
                    if (ctrl_wr[n] && WBs_WR_DAT[0]) begin
                        state_d[n] = S_RUN;
                        count_d[n] = load[n];
                    end
                end
                S_RUN: begin
                    // a disable write pre-empts any tick in the same cycle
                    if (ctrl_wr[n] && !WBs_WR_DAT[0]) begin
                        state_d[n] = S_IDLE;
                    end else if (tick) begin
                        if (count[n] != '0) begin
                            count_d[n] = count[n] - CNT_WIDTH'(1);
                        end else begin
                            expire[n] = 1'b1;
                            if (mode[n]) count_d[n] = load[n];
                            else         state_d[n] = S_IDLE;
                        end
                    end
                end
                default: state_d[n] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge WB_CLK) begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (WB_RST) begin
                state[n] <= S_IDLE;
                load[n]  <= '0;
                count[n] <= '0;
            end else begin
                state[n] <= state_d[n];
                load[n]  <= load_d[n];
                count[n] <= count_d[n];
            end
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            WBs_ACK     <= 1'b0;
            WBs_RD_DAT  <= '0;
            pre_cnt     <= '0;
            prescale    <= '0;
            int_en      <= '0;
            int_stat    <= '0;
            mode        <= '0;
            tmr_pulse_o <= '0;
        end else begin
            WBs_ACK <= req;
            if (rd) WBs_RD_DAT <= rd_d;
            if ((wr && idx == A_PRE) || tick) pre_cnt <= '0;
            else                              pre_cnt <= pre_cnt + PRE_WIDTH'(1);
            prescale    <= prescale_d;
            int_en      <= int_en_d;
            int_stat    <= int_stat_d;
            mode        <= mode_d;
            tmr_pulse_o <= expire;
        end
    end
endmodule

// File: tb/tb_wb_timer_ctrl_mc.sv
// Self-checking bench for wb_timer_ctrl_mc: expiry times are predicted arithmetically
// from the prescaler phase, enable/disable commit edges, LOAD and MODE.
module tb_wb_timer_ctrl_mc;
    localparam int NCH = 4;
    localparam logic [16:0] A_ID   = 17'h00;
    localparam logic [16:0] A_STAT = 17'h04;
    localparam logic [16:0] A_EN   = 17'h08;
    localparam logic [16:0] A_PRE  = 17'h0C;

    logic           WB_CLK = 1'b0;
    logic           WB_RST = 1'b1;
    logic [16:0]    WBs_ADR = '0;
    logic           WBs_CYC = 1'b0;
    logic [3:0]     WBs_BYTE_STB = '0;
    logic           WBs_WE = 1'b0;
    logic           WBs_RD = 1'b0;
    logic           WBs_STB = 1'b0;
    logic [31:0]    WBs_WR_DAT = '0;
    logic [31:0]    WBs_RD_DAT;
    logic           WBs_ACK;
    logic [NCH-1:0] tmr_pulse_o;
    logic           FPGA_INTR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_commit = 0;
    int pulse_log[$];

    wb_timer_ctrl_mc #(
        .NUM_CH(4), .CNT_WIDTH(32), .PRE_WIDTH(16), .DEV_ID(16'hC008)
    ) dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST), .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC),
        .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WE(WBs_WE), .WBs_RD(WBs_RD), .WBs_STB(WBs_STB),
        .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .tmr_pulse_o(tmr_pulse_o), .FPGA_INTR(FPGA_INTR)
    );

    always #5 WB_CLK = ~WB_CLK;
    always @(posedge WB_CLK) cyc <= cyc + 1;

    // log every pulse as edge*8+channel, edge = clock edge that registered it
    always @(posedge WB_CLK) begin
        #1;
        for (int c = 0; c < NCH; c++)
            if (tmr_pulse_o[c]) pulse_log.push_back(cyc * 8 + c);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [16:0] ch_addr(input int c, input int off);
        return 17'(16 + 16 * c + off);
    endfunction

    function automatic int first_tick(input int w, input int p, input int e);
        return w + ((e - w) / (p + 1) + 1) * (p + 1);
    endfunction

    // ticks on edges strictly between e and d
    function automatic int ticks_between(input int w, input int p, input int e, input int d);
        return (d - 1 - w) / (p + 1) - (e - w) / (p + 1);
    endfunction

    task automatic bus_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be,
                             output int commit, output logic ack, output logic intr_after);
        WBs_ADR = a; WBs_WR_DAT = d; WBs_BYTE_STB = be;
        WBs_WE = 1'b1; WBs_CYC = 1'b1; WBs_STB = 1'b1;
        @(negedge WB_CLK);
        commit = cyc; ack = WBs_ACK; intr_after = FPGA_INTR;
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0; WBs_BYTE_STB = '0;
        @(negedge WB_CLK);
    endtask

    task automatic wr(input logic [16:0] a, input logic [31:0] d);
        int c;
        logic k, i;
        bus_write(a, d, 4'hF, c, k, i);
        last_commit = c;
    endtask

    task automatic bus_read(input logic [16:0] a, output logic [31:0] d,
                            output logic ack1, output logic ack2);
        WBs_ADR = a; WBs_WE = 1'b0; WBs_CYC = 1'b1; WBs_STB = 1'b1; WBs_BYTE_STB = 4'hF;
        @(negedge WB_CLK);
        ack1 = WBs_ACK; d = WBs_RD_DAT;
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_BYTE_STB = '0;
        @(negedge WB_CLK);
        ack2 = WBs_ACK;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a1, a2;
        WB_RST = 1'b1;
        repeat (3) @(negedge WB_CLK);
        checks++;
        if ({WBs_ACK, FPGA_INTR, tmr_pulse_o, WBs_RD_DAT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b intr=%b pulse=%b rd=%h, all required 0",
                     WBs_ACK, FPGA_INTR, tmr_pulse_o, WBs_RD_DAT);
        end
        WB_RST = 1'b0;
        bus_read(A_ID, d, a1, a2);
        checks++;
        if (d !== 32'hC008_0420) begin
            errors++; $display("FAIL id_read: got %h want c0080420", d);
        end
        checks++;
        if ({a1, a2} !== 2'b10) begin
            errors++; $display("FAIL id_ack_timing: ack(+1,+2)=%b%b want 10", a1, a2);
        end
        bus_read(A_STAT, d, a1, a2);
        checks++;
        if (d !== 32'h0 || FPGA_INTR !== 1'b0) begin
            errors++; $display("FAIL reset_int_stat: stat=%h intr=%b want 0/0", d, FPGA_INTR);
        end
        bus_read(A_PRE, d, a1, a2);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_prescale: got %h want 0", d);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic a1, a2;
        int e, n, first;
        wr(A_PRE, 0);
        wr(ch_addr(0, 4), 5);
        wr(A_EN, 1);
        pulse_log.delete();
        wr(ch_addr(0, 0), 32'h1);
        e = last_commit;
        repeat (12) @(negedge WB_CLK);
        n = 0; first = -1;
        foreach (pulse_log[i])
            if (pulse_log[i] % 8 == 0) begin
                n++;
                if (first < 0) first = pulse_log[i] / 8;
            end
        checks++;
        if (n != 1 || first != e + 6) begin
            errors++;
            $display("FAIL oneshot_pulse: count=%0d at edge %0d, want 1 at edge %0d", n, first, e + 6);
        end
        bus_read(A_STAT, d, a1, a2);
        checks++;
        if (d !== 32'h1 || FPGA_INTR !== 1'b1) begin
            errors++; $display("FAIL oneshot_int: stat=%h intr=%b want 1/1", d, FPGA_INTR);
        end
        bus_read(ch_addr(0, 0), d, a1, a2);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL oneshot_ctrl: got %h want 0", d);
        end
        bus_read(ch_addr(0, 8), d, a1, a2);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL oneshot_count: got %h want 0", d);
        end
        wr(A_STAT, 32'h1);
        checks++;
        if (FPGA_INTR !== 1'b0) begin
            errors++; $display("FAIL oneshot_clear: intr=%b want 0", FPGA_INTR);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d1, d2;
        logic a1, a2;
        int w, e, dd, t1, t, n, expc;
        int act[$];
        int expq[$];
        wr(A_PRE, 3);
        w = last_commit;
        wr(ch_addr(1, 4), 2);
        pulse_log.delete();
        wr(ch_addr(1, 0), 32'h3);
        e = last_commit;
        repeat (30) @(negedge WB_CLK);
        wr(ch_addr(1, 0), 32'h3);   // re-enable while running: no reload
        repeat (40) @(negedge WB_CLK);
        wr(ch_addr(1, 0), 32'h0);
        dd = last_commit;
        bus_read(ch_addr(1, 8), d1, a1, a2);
        repeat (20) @(negedge WB_CLK);
        bus_read(ch_addr(1, 8), d2, a1, a2);
        t1 = first_tick(w, 3, e);
        for (int k = 1; k < 100; k++) begin
            t = t1 + (3 * k - 1) * 4;
            if (t >= dd) break;
            expq.push_back(t);
        end
        foreach (pulse_log[i]) if (pulse_log[i] % 8 == 1) act.push_back(pulse_log[i] / 8);
        checks++;
        if (act.size() < 4) begin
            errors++; $display("FAIL periodic_count: got %0d pulses want at least 4", act.size());
        end
        checks++;
        if (act != expq) begin
            errors++;
            $display("FAIL periodic_times: got %0d pulses (first %0d) want %0d pulses (first %0d)",
                     act.size(), (act.size() > 0) ? act[0] : -1, expq.size(), (expq.size() > 0) ? expq[0] : -1);
        end
        n = ticks_between(w, 3, e, dd);
        expc = 2 - (n % 3);
        checks++;
        if (d1 !== 32'(expc) || d2 !== 32'(expc)) begin
            errors++; $display("FAIL periodic_freeze: count=%0d then %0d want %0d", d1, d2, expc);
        end
        wr(A_STAT, 32'hF);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic a1, a2, k, intr_after;
        int e, tt, c, n, first;
        wr(A_PRE, 0);
        wr(ch_addr(2, 4), 10);
        pulse_log.delete();
        wr(ch_addr(2, 0), 32'h1);
        e = last_commit;
        tt = e + 11;
        for (int g = 0; g < 50 && cyc < tt - 1; g++) @(negedge WB_CLK);
        bus_write(A_STAT, 32'h4, 4'hF, c, k, intr_after);
        checks++;
        if (c != tt) begin
            errors++; $display("FAIL w1c_alignment: write committed at %0d want %0d", c, tt);
        end
        n = 0; first = -1;
        foreach (pulse_log[i])
            if (pulse_log[i] % 8 == 2) begin
                n++;
                if (first < 0) first = pulse_log[i] / 8;
            end
        checks++;
        if (n != 1 || first != tt) begin
            errors++; $display("FAIL w1c_pulse: count=%0d at %0d want 1 at %0d", n, first, tt);
        end
        bus_read(A_STAT, d, a1, a2);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL w1c_set_wins: stat=%h want 4", d);
        end
        wr(A_EN, 32'h4);
        checks++;
        if (FPGA_INTR !== 1'b1) begin
            errors++; $display("FAIL w1c_intr_on: intr=%b want 1", FPGA_INTR);
        end
        bus_write(A_STAT, 32'h4, 4'hF, c, k, intr_after);
        checks++;
        if (intr_after !== 1'b0) begin
            errors++; $display("FAIL w1c_intr_drop: intr=%b want 0", intr_after);
        end
    endtask

    task automatic test_bytes_unmapped();
        logic [31:0] d;
        logic a1, a2, k, ia;
        int c;
        wr(ch_addr(3, 4), 32'h0);
        bus_write(ch_addr(3, 4), 32'hAABBCCDD, 4'b0101, c, k, ia);
        bus_read(ch_addr(3, 4), d, a1, a2);
        checks++;
        if (d !== 32'h00BB00DD) begin
            errors++; $display("FAIL byte_strobe: got %h want 00bb00dd", d);
        end
        bus_write(17'hFC, 32'hFFFFFFFF, 4'hF, c, k, ia);
        checks++;
        if (k !== 1'b1) begin
            errors++; $display("FAIL unmapped_wr_ack: ack=%b want 1", k);
        end
        bus_read(17'hFC, d, a1, a2);
        checks++;
        if (d !== 32'h0 || a1 !== 1'b1) begin
            errors++; $display("FAIL unmapped_rd: data=%h ack=%b want 0/1", d, a1);
        end
        bus_read(ch_addr(3, 12), d, a1, a2);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped_ch_slot: got %h want 0", d);
        end
        wr(A_ID, 32'h12345678);
        bus_read(A_ID, d, a1, a2);
        checks++;
        if (d !== 32'hC008_0420) begin
            errors++; $display("FAIL id_readonly: got %h want c0080420", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic a1, a2;
        int p, w, n, expc, t1, t, exp_stat;
        int ld[NCH];
        int md[NCH];
        int en_e[NCH];
        int dis_d[NCH];
        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(0, 3);
            wr(A_STAT, 32'hF);
            wr(A_PRE, 32'(p));
            w = last_commit;
            for (int c = 0; c < NCH; c++) begin
                ld[c] = $urandom_range(0, 6);
                md[c] = $urandom_range(0, 1);
                wr(ch_addr(c, 4), 32'(ld[c]));
            end
            pulse_log.delete();
            for (int c = 0; c < NCH; c++) begin
                wr(ch_addr(c, 0), 32'(2 * md[c] + 1));
                en_e[c] = last_commit;
            end
            repeat ($urandom_range(20, 80)) @(negedge WB_CLK);
            for (int c = 0; c < NCH; c++) begin
                wr(ch_addr(c, 0), 32'(2 * md[c]));
                dis_d[c] = last_commit;
            end
            repeat (4) @(negedge WB_CLK);
            exp_stat = 0;
            for (int c = 0; c < NCH; c++) begin
                int act[$];
                int expq[$];
                t1 = first_tick(w, p, en_e[c]);
                for (int k = 1; k < 200; k++) begin
                    t = t1 + ((ld[c] + 1) * k - 1) * (p + 1);
                    if (t >= dis_d[c]) break;
                    expq.push_back(t);
                    if (md[c] == 0) break;
                end
                if (expq.size() > 0) exp_stat |= (1 << c);
                foreach (pulse_log[i]) if (pulse_log[i] % 8 == c) act.push_back(pulse_log[i] / 8);
                checks++;
                if (act != expq) begin
                    errors++;
                    $display("FAIL rand_pulses it%0d ch%0d: got %0d pulses want %0d (P=%0d L=%0d M=%0d)",
                             it, c, act.size(), expq.size(), p, ld[c], md[c]);
                end
                n = ticks_between(w, p, en_e[c], dis_d[c]);
                if (md[c] != 0) expc = ld[c] - (n % (ld[c] + 1));
                else            expc = (n >= ld[c] + 1) ? 0 : ld[c] - n;
                bus_read(ch_addr(c, 8), d, a1, a2);
                checks++;
                if (d !== 32'(expc)) begin
                    errors++; $display("FAIL rand_count it%0d ch%0d: got %0d want %0d", it, c, d, expc);
                end
                bus_read(ch_addr(c, 0), d, a1, a2);
                checks++;
                if (d !== 32'(2 * md[c])) begin
                    errors++; $display("FAIL rand_ctrl it%0d ch%0d: got %h want %0d", it, c, d, 2 * md[c]);
                end
            end
            bus_read(A_STAT, d, a1, a2);
            checks++;
            if (d !== 32'(exp_stat)) begin
                errors++; $display("FAIL rand_int_stat it%0d: got %h want %h", it, d, exp_stat);
            end
        end
        wr(A_STAT, 32'hF);
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        logic a1, a2;
        wr(A_PRE, 0);
        wr(A_EN, 32'hF);
        for (int c = 0; c < NCH; c++) begin
            wr(ch_addr(c, 4), 32'(1 + c));
            wr(ch_addr(c, 0), 32'h3);
        end
        repeat (10) @(negedge WB_CLK);
        WB_RST = 1'b1;
        pulse_log.delete();
        @(negedge WB_CLK);
        WB_RST = 1'b0;
        checks++;
        if (FPGA_INTR !== 1'b0 || tmr_pulse_o !== '0) begin
            errors++; $display("FAIL midrun_outputs: intr=%b pulse=%b want 0/0", FPGA_INTR, tmr_pulse_o);
        end
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] dc;
            bus_read(ch_addr(c, 0), d, a1, a2);
            bus_read(ch_addr(c, 8), dc, a1, a2);
            checks++;
            if (d !== 32'h0 || dc !== 32'h0) begin
                errors++; $display("FAIL midrun_ch%0d: ctrl=%h count=%h want 0/0", c, d, dc);
            end
        end
        bus_read(A_STAT, d, a1, a2);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL midrun_int_stat: got %h want 0", d);
        end
        repeat (30) @(negedge WB_CLK);
        checks++;
        if (pulse_log.size() != 0) begin
            errors++; $display("FAIL midrun_no_pulse: got %0d pulses want 0", pulse_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_w1c_collision();
        test_bytes_unmapped();
        test_random();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_timer_ctrl_mc.md
Name: wb_timer_ctrl_mc

Overview:
Parametrised multi-channel timer controller. It sits inside the FPGA IP as a Wishbone slave behind the AHB-to-FPGA bridge and is clocked from the Wishbone clock domain. It provides NUM_CH independent down-counters sharing one prescaler, each with one-shot or periodic mode. Expiries drive per-channel pulse outputs and a maskable, sticky interrupt that feeds the cell macro's FB_msg_out.

Parameters:
- NUM_CH, 4, number of timer channels, legal range 1..8.
- CNT_WIDTH, 32, counter/LOAD width, legal range 8..32; register bits above CNT_WIDTH read 0.
- PRE_WIDTH, 16, prescaler width, legal range 1..16.
- DEV_ID, 16'hC008, value returned in ID[31:16].

Ports:
- WB_CLK  input  1  single clock for all logic.
- WB_RST  input  1  reset, synchronous, active-high.
- WBs_ADR  input  17  byte address; only [7:2] are decoded.
- WBs_CYC  input  1  cycle/chip select.
- WBs_BYTE_STB  input  4  byte enables.
- WBs_WE  input  1  write enable.
- WBs_RD  input  1  read enable; ignored, reads are decoded from ~WBs_WE.
- WBs_STB  input  1  transfer strobe.
- WBs_WR_DAT  input  32  write data.
- WBs_RD_DAT  output  32  read data, registered.
- WBs_ACK  output  1  transfer acknowledge.
- tmr_pulse_o  output  NUM_CH  one-cycle pulse per channel on expiry.
- FPGA_INTR  output  1  level interrupt = |(INT_STAT & INT_EN).

Behaviour:
- Clocking/reset: one clock, WB_CLK. Reset is synchronous and active-high on WB_RST.
- Reset values: all registers, counters and prescaler 0; WBs_ACK=0, WBs_RD_DAT=0, tmr_pulse_o=0, FPGA_INTR=0.
- Reset mid-operation: all channels stop and clear on the next edge; no pulse is emitted.
- Wishbone access:
  - req = WBs_CYC & WBs_STB & ~WBs_ACK.
  - WBs_ACK <= req, giving a single-cycle ACK one cycle after the strobe; back-to-back accesses take 2 cycles each.
  - A write commits on the req cycle, per byte lane as gated by WBs_BYTE_STB.
  - WBs_RD_DAT is registered on the req cycle, so it is valid together with ACK.
  - Unmapped addresses read 0, ignore writes, and still ACK.
- Register map (byte offsets):
  - 0x00 ID (RO) = {DEV_ID, NUM_CH[7:0], CNT_WIDTH[7:0]}.
  - 0x04 INT_STAT (W1C), bits [NUM_CH-1:0].
  - 0x08 INT_EN (RW), bits [NUM_CH-1:0].
  - 0x0C PRESCALE (RW), bits [PRE_WIDTH-1:0].
  - Channel n, base 0x10+0x10*n:
    - +0 CTRL (RW): bit0 EN, bit1 MODE (0 one-shot, 1 periodic).
    - +4 LOAD (RW).
    - +8 COUNT (RO).
- Prescaler:
  - pre_cnt increments every clock.
  - When pre_cnt==PRESCALE: pre_cnt<=0 and tick=1 for that cycle. A tick therefore occurs every PRESCALE+1 clocks; PRESCALE=0 gives a tick every clock.
  - Writing PRESCALE clears pre_cnt in the same cycle.
- Channel state machine, two states: IDLE (EN=0) and RUN (EN=1).
  - EN 0->1 write: COUNT<=LOAD, state RUN. The first decrement occurs on the next tick.
  - RUN, tick, COUNT!=0: COUNT<=COUNT-1.
  - RUN, tick, COUNT==0: expiry.
    - tmr_pulse_o[n]=1 for one cycle; INT_STAT[n]<=1.
    - Periodic: COUNT<=LOAD and stay in RUN. Period = (LOAD+1) ticks; LOAD=0 expires every tick.
    - One-shot: EN<=0, go to IDLE, COUNT holds at 0.
  - EN 1->0 write: go to IDLE immediately; COUNT freezes; a tick in the same cycle is ignored.
  - EN write 1 while already 1: no reload.
  - LOAD write while in RUN: takes effect at the next reload only.
- Simultaneous events:
  - Hardware set and W1C of the same INT_STAT bit in the same cycle: set wins.
  - Several channels expiring on one tick: all bits set, all pulses asserted together.
- FPGA_INTR is combinational from the INT_STAT and INT_EN registers and has no extra latency.
- Arithmetic: COUNT is unsigned CNT_WIDTH bits. COUNT is never decremented below 0, because expiry is detected at 0.

Test Plan:
- Reset/ID:
  - Assert WB_RST for 3 clocks, then read 0x00 -> 0xC008_0420, with ACK exactly 1 cycle after STB.
  - Read 0x04 -> 0; FPGA_INTR=0.
- One-shot, channel 0:
  - PRESCALE=0, LOAD0=5, INT_EN=1, CTRL0=0x1.
  - tmr_pulse_o[0] fires 6 clocks after the write commit.
  - INT_STAT=0x1; FPGA_INTR=1; CTRL0 reads 0; COUNT0 reads 0.
- Periodic with prescale, channel 1:
  - PRESCALE=3, LOAD1=2, CTRL1=0x3.
  - Pulses arrive every 12 clocks for at least 4 periods.
  - Write CTRL1=0 -> COUNT1 freezes and no further pulses.
- W1C collision:
  - Arrange a channel-2 expiry on the same cycle as a write INT_STAT=0x4 -> bit 2 remains 1.
  - A later write of 0x4 clears it and FPGA_INTR drops on the next cycle.
- Byte strobes and unmapped access:
  - Write LOAD3=0xAABBCCDD with BYTE_STB=4'b0101 -> reads 0x00BB00DD.
  - Write and read 0xFC -> ACK given, read returns 0.
- Reset mid-run:
  - With all 4 channels periodic, assert WB_RST for 1 clock.
  - All COUNT, CTRL and INT_STAT read 0, and no tmr_pulse_o occurs afterwards.
